cpu_test_sequencer: RTL and testbench
=====================================

# cpu_test_sequencer

Parametrised, synthesisable self-checking test sequencer for the CPU bench; the successor to the fixed begintest/endtest/dutpassed tester. It steps through NUM_TESTS test slots and launches each with a start pulse. It waits for the DUT's done strobe or a timeout, then compares the captured result against an expected value and accumulates pass/fail statistics. It sits between the top-level bench and the CPU (or any DUT with a start/done handshake) and drives the same endtest/dutpassed completion signals.

## Interface
- NUM_TESTS, 8, number of test slots (≥1)
- DATA_WIDTH, 32, width of result/expected words
- TIMEOUT, 1000, max WAIT cycles per test before declaring failure (≥2)
- IDX_WIDTH, $clog2(NUM_TESTS) (min 1), derived, test index width
- clk  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-high
- begintest  in  1  level input; a rising edge (sampled vs. registered previous value) starts a run
- dut_start  out  1  one-cycle start pulse for current test
- test_idx  out  IDX_WIDTH  index of current test (drives external expected-value ROM)
- dut_done  in  1  DUT completion strobe
- dut_result  in  DATA_WIDTH  DUT result, valid when dut_done=1
- expected  in  DATA_WIDTH  expected value for test_idx, combinational from ROM
- endtest  out  1  high while run complete
- dutpassed  out  1  high in DONE iff fail_count==0
- fail_count  out  IDX_WIDTH+1  number of failed tests this run
- first_fail_idx  out  IDX_WIDTH  index of first failing test (0 if none)
- timeout_seen  out  1  sticky: some test in this run timed out

## Operation
- States: IDLE, LAUNCH, WAIT, CHECK, DONE.
- IDLE: on begintest rising edge, clear test_idx, fail_count, first_fail_idx, timeout_seen, timer; go to LAUNCH.
- LAUNCH: dut_start=1 (Moore output); clear timer; go to WAIT. dut_done during LAUNCH is ignored.
- WAIT: if dut_done, capture dut_result, go to CHECK. Otherwise increment timer. When timer reaches TIMEOUT-1 with no done, record a failure, set timeout_seen, and advance as from CHECK.
- dut_done and timeout in the same cycle: done wins; the test is compared normally.
- CHECK: mismatch (captured result != expected) → fail_count+1. If this is the first failure, first_fail_idx=test_idx. If test_idx==NUM_TESTS-1 → DONE, else test_idx+1 → LAUNCH.
- DONE: endtest=1, dutpassed=(fail_count==0). All status outputs hold. A new begintest rising edge restarts exactly as from IDLE.
- begintest held high continuously does not retrigger; only a 0→1 transition does. Edges seen outside IDLE/DONE are ignored.
- fail_count cannot overflow (max NUM_TESTS fits in IDX_WIDTH+1 bits).

## Timing
- Reset values: dut_start=0, test_idx=0, endtest=0, dutpassed=0, fail_count=0, first_fail_idx=0, timeout_seen=0, state=IDLE, prev-begintest=0.
- Reset asserted mid-run returns to IDLE with reset values on the next edge. The in-flight test is abandoned.
- Edge detected at clock edge k → dut_start high during cycle k..k+1.
- dut_done sampled at edge m in WAIT → CHECK in cycle m..m+1 → next LAUNCH or DONE at edge m+1.
- Minimum per-test cost is 3 cycles (LAUNCH, one WAIT, CHECK). A timed-out test costs 1+TIMEOUT cycles and skips CHECK.
- endtest rises one cycle after the last CHECK (or last timeout) and stays high until reset or restart.

## Structure
- Package cpu_test_pkg: state enum (IDLE/LAUNCH/WAIT/CHECK/DONE) and the default-parameter constants.
- Sub-module timeout_counter (parameter TIMEOUT): inputs clk, reset, clear, enable; output expired. It encapsulates the WAIT timer.
- The FSM, edge detect, capture register and statistics live in the top.

## Test plan
- NUM_TESTS=4; DUT returns done after 5 cycles with result==expected for all → endtest=1, dutpassed=1, fail_count=0, timeout_seen=0, 4 dut_start pulses.
- Same, but test 2 returns 32'hDEADBEEF vs expected 32'h0000_0007, and test 3 also mismatches → fail_count=2, first_fail_idx=2, dutpassed=0.
- TIMEOUT=10; DUT never answers test 1 → after 10 WAIT cycles it advances to test 2; timeout_seen=1, fail_count=1, first_fail_idx=1.
- TIMEOUT=10; dut_done asserted exactly on the expiry cycle with a correct result → counted as pass, timeout_seen=0.
- reset pulsed during WAIT of test 2 → all outputs at reset values next cycle. Holding begintest high without a new edge starts nothing; toggling it 0→1 restarts from test 0.
- In DONE, begintest 1→0→1 → statistics cleared, second full run executes with identical results.

Source files
------------

// File: rtl/cpu_test_pkg.sv
// ---------------------------------------------------------------------------
// cpu_test_pkg
// Shared types and default parameter values for the CPU test sequencer.
//   state_t         : sequencer FSM states
//   DEF_NUM_TESTS   : default number of test slots
//   DEF_DATA_WIDTH  : default result / expected word width
//   DEF_TIMEOUT     : default WAIT-cycle budget per test
// ---------------------------------------------------------------------------
package cpu_test_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_WAIT,
        ST_CHECK,
        ST_DONE
    } state_t;

    localparam int unsigned DEF_NUM_TESTS  = 8;
    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam int unsigned DEF_TIMEOUT    = 1000;

endpackage

// File: rtl/cpu_test_sequencer_timeout_counter.sv
// ---------------------------------------------------------------------------
// timeout_counter
// Per-test WAIT timer. Counts enabled cycles from zero and flags expiry on
// the TIMEOUT-th enabled cycle after a clear.
//   i_clk     : clock, rising edge
//   i_reset   : synchronous active-high reset
//   i_clear   : synchronous clear to zero (takes priority over enable)
//   i_enable  : count this cycle
//   o_expired : count has reached TIMEOUT-1
// ---------------------------------------------------------------------------
module timeout_counter
    import cpu_test_pkg::*;
#(
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int unsigned CW = $clog2(TIMEOUT);

    logic [CW-1:0] r_count;

    assign o_expired = (r_count == CW'(TIMEOUT - 1));

    // Saturate at the expiry value so a done arriving on the expiry cycle
    // never lets the count wrap before the next clear.
    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            r_count <= '0;
        end else if (i_enable && !o_expired) begin
            r_count <= r_count + CW'(1);
        end
    end

endmodule

// File: rtl/cpu_test_sequencer.sv
// ---------------------------------------------------------------------------
// cpu_test_sequencer
// Steps through NUM_TESTS test slots: pulses a start, waits for the DUT's
// done strobe (or a timeout), compares the captured result with the value
// from the external expected-value ROM and accumulates pass/fail stats.
//   i_clk, i_reset     : clock / synchronous active-high reset
//   i_begintest        : level; a 0->1 transition starts a run (IDLE/DONE)
//   o_dut_start        : one-cycle start pulse for the current test
//   o_test_idx         : current test index (addresses the expected ROM)
//   i_dut_done         : DUT completion strobe
//   i_dut_result       : DUT result, valid with i_dut_done
//   i_expected         : expected value for o_test_idx
//   o_endtest          : run complete
//   o_dutpassed        : run complete with no failures
//   o_fail_count       : failed tests this run
//   o_first_fail_idx   : index of first failing test (0 if none)
//   o_timeout_seen     : some test in this run timed out
// ---------------------------------------------------------------------------
module cpu_test_sequencer
    import cpu_test_pkg::*;
#(
    parameter int unsigned NUM_TESTS  = DEF_NUM_TESTS,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned TIMEOUT    = DEF_TIMEOUT,
    parameter int unsigned IDX_WIDTH  = (NUM_TESTS > 1) ? $clog2(NUM_TESTS) : 1
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_begintest,
    output logic                  o_dut_start,
    output logic [IDX_WIDTH-1:0]  o_test_idx,
    input  logic                  i_dut_done,
    input  logic [DATA_WIDTH-1:0] i_dut_result,
    input  logic [DATA_WIDTH-1:0] i_expected,
    output logic                  o_endtest,
    output logic                  o_dutpassed,
    output logic [IDX_WIDTH:0]    o_fail_count,
    output logic [IDX_WIDTH-1:0]  o_first_fail_idx,
    output logic                  o_timeout_seen
);

    localparam int unsigned FW = IDX_WIDTH + 1;

    state_t                r_state;
    state_t                w_state_next;
    logic                  r_prev_begin;
    logic [IDX_WIDTH-1:0]  r_test_idx;
    logic [FW-1:0]         r_fail_count;
    logic [IDX_WIDTH-1:0]  r_first_fail_idx;
    logic                  r_timeout_seen;
    logic [DATA_WIDTH-1:0] r_result;

    logic w_begin_edge;
    logic w_start_run;
    logic w_expired;
    logic w_timeout;
    logic w_last;
    logic w_fail_now;
    logic w_advance;

    assign w_begin_edge = i_begintest && !r_prev_begin;
    assign w_start_run  = w_begin_edge && (r_state == ST_IDLE || r_state == ST_DONE);
    assign w_last       = (r_test_idx == IDX_WIDTH'(NUM_TESTS - 1));
    // Done wins over expiry in the same cycle.
    assign w_timeout    = (r_state == ST_WAIT) && !i_dut_done && w_expired;
    assign w_fail_now   = ((r_state == ST_CHECK) && (r_result != i_expected)) || w_timeout;
    // A timeout skips CHECK and moves on exactly as CHECK would.
    assign w_advance    = (r_state == ST_CHECK) || w_timeout;

    timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_clear   (r_state != ST_WAIT),
        .i_enable  (r_state == ST_WAIT),
        .o_expired (w_expired)
    );

    // State register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE,
            ST_DONE:   if (w_begin_edge) w_state_next = ST_LAUNCH;
            ST_LAUNCH: w_state_next = ST_WAIT;
            ST_WAIT: begin
                if (i_dut_done) begin
                    w_state_next = ST_CHECK;
                end else if (w_expired) begin
                    w_state_next = w_last ? ST_DONE : ST_LAUNCH;
                end
            end
            ST_CHECK:  w_state_next = w_last ? ST_DONE : ST_LAUNCH;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    // Moore outputs
    always_comb begin
        o_dut_start = 1'b0;
        o_endtest   = 1'b0;
        o_dutpassed = 1'b0;
        case (r_state)
            ST_LAUNCH: o_dut_start = 1'b1;
            ST_DONE: begin
                o_endtest   = 1'b1;
                o_dutpassed = (r_fail_count == '0);
            end
            default: ;
        endcase
    end

    // Edge detect, result capture and run statistics
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_prev_begin     <= 1'b0;
            r_test_idx       <= '0;
            r_fail_count     <= '0;
            r_first_fail_idx <= '0;
            r_timeout_seen   <= 1'b0;
            r_result         <= '0;
        end else begin
            r_prev_begin <= i_begintest;
            if (w_start_run) begin
                r_test_idx       <= '0;
                r_fail_count     <= '0;
                r_first_fail_idx <= '0;
                r_timeout_seen   <= 1'b0;
            end else begin
                if (r_state == ST_WAIT && i_dut_done) begin
                    r_result <= i_dut_result;
                end
                if (w_fail_now) begin
                    r_fail_count <= r_fail_count + FW'(1);
                    if (r_fail_count == '0) begin
                        r_first_fail_idx <= r_test_idx;
                    end
                end
                if (w_timeout) begin
                    r_timeout_seen <= 1'b1;
                end
                if (w_advance && !w_last) begin
                    r_test_idx <= r_test_idx + IDX_WIDTH'(1);
                end
            end
        end
    end

    assign o_test_idx       = r_test_idx;
    assign o_fail_count     = r_fail_count;
    assign o_first_fail_idx = r_first_fail_idx;
    assign o_timeout_seen   = r_timeout_seen;

endmodule

// File: tb/tb_cpu_test_sequencer.sv
// ---------------------------------------------------------------------------
// tb_cpu_test_sequencer
// Bench for cpu_test_sequencer with NUM_TESTS=4, TIMEOUT=10. A responder
// plays the DUT (done after a configured number of WAIT cycles, optionally
// with a wrong result). The model computes each run's timeline from per-test
// costs (2+delay, or 1+TIMEOUT on timeout) and derives every output per cycle.
// ---------------------------------------------------------------------------
module tb_cpu_test_sequencer;

    localparam int NT = 4;
    localparam int DW = 32;
    localparam int TO = 10;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          begintest;
    logic          dut_done;
    logic [DW-1:0] dut_result;
    logic [DW-1:0] expected;
    logic          o_dut_start;
    logic [IW-1:0] o_test_idx;
    logic          o_endtest;
    logic          o_dutpassed;
    logic [IW:0]   o_fail_count;
    logic [IW-1:0] o_first_fail_idx;
    logic          o_timeout_seen;

    cpu_test_sequencer #(
        .NUM_TESTS  (NT),
        .DATA_WIDTH (DW),
        .TIMEOUT    (TO)
    ) dut (
        .i_clk            (clk),
        .i_reset          (reset),
        .i_begintest      (begintest),
        .o_dut_start      (o_dut_start),
        .o_test_idx       (o_test_idx),
        .i_dut_done       (dut_done),
        .i_dut_result     (dut_result),
        .i_expected       (expected),
        .o_endtest        (o_endtest),
        .o_dutpassed      (o_dutpassed),
        .o_fail_count     (o_fail_count),
        .o_first_fail_idx (o_first_fail_idx),
        .o_timeout_seen   (o_timeout_seen)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] rom [NT] = '{32'h0000_0011, 32'h0000_0022, 32'h0000_0007, 32'h0000_0044};
    assign expected = rom[o_test_idx];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            if (n_errors <= 40)
                $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    // ---------------- test configuration & responder ----------------
    int dly [NT];      // done in this WAIT cycle (1-based); 0 = never
    bit mis [NT];      // respond with a wrong result
    bit noise = 1'b0;  // also raise done (garbage) during LAUNCH
    int nstart = 0;

    initial begin
        int  ridx;
        int  rcnt;
        bit  armed;
        armed = 1'b0; ridx = 0; rcnt = 0;
        dut_done = 1'b0; dut_result = '0;
        forever begin
            @(posedge clk); #2;
            dut_done = 1'b0;
            dut_result = '0;
            if (o_dut_start) begin
                ridx = int'(o_test_idx);
                rcnt = 0;
                armed = 1'b1;
                nstart++;
                if (noise) begin
                    dut_done = 1'b1;
                    dut_result = 32'hBAD0_BAD0;
                end
            end else if (armed) begin
                rcnt++;
                if (rcnt == dly[ridx]) begin
                    dut_done = 1'b1;
                    if (!mis[ridx])   dut_result = rom[ridx];
                    else if (ridx == 2) dut_result = 32'hDEADBEEF;
                    else              dut_result = ~rom[ridx];
                    armed = 1'b0;
                end
            end
        end
    end

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic        start;
        logic        endt;
        logic        pass;
        logic        to;
        logic [31:0] idx;
        logic [31:0] fail;
        logic [31:0] ffi;
    } exp_t;

    int   m_mode = 0;   // 0: reset values, 1: run timeline
    int   m_from = 0;   // cycle from which the current mode applies
    int   m_L0   = 0;   // launch cycle of test 0
    exp_t m_prev = '0;  // expectations before m_from

    function automatic int cost(int i);
        if (dly[i] == 0 || dly[i] > TO) return 1 + TO;
        return 2 + dly[i];
    endfunction

    function automatic int run_len();
        int s = 0;
        for (int i = 0; i < NT; i++) s += cost(i);
        return s;
    endfunction

    function automatic exp_t run_at(int c);
        exp_t e = '0;
        int   t = m_L0;
        for (int i = 0; i < NT; i++) begin
            if (c < t + cost(i)) begin
                e.idx   = i;
                e.start = (c == t);
                return e;
            end
            // outcome of test i becomes visible when the next slot begins
            if (dly[i] == 0 || dly[i] > TO || mis[i]) begin
                if (e.fail == 0) e.ffi = i;
                e.fail++;
            end
            if (dly[i] == 0 || dly[i] > TO) e.to = 1'b1;
            t += cost(i);
        end
        e.idx  = NT - 1;
        e.endt = 1'b1;
        e.pass = (e.fail == 0);
        return e;
    endfunction

    function automatic exp_t model_at(int c);
        if (c < m_from) return m_prev;
        if (m_mode == 0) return '0;
        return run_at(c);
    endfunction

    bit chk_on = 1'b0;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (chk_on) begin
                e = model_at(cyc);
                chk("dut_start",      64'(o_dut_start),      64'(e.start));
                chk("test_idx",       64'(o_test_idx),       64'(e.idx));
                chk("endtest",        64'(o_endtest),        64'(e.endt));
                chk("dutpassed",      64'(o_dutpassed),      64'(e.pass));
                chk("fail_count",     64'(o_fail_count),     64'(e.fail));
                chk("first_fail_idx", 64'(o_first_fail_idx), 64'(e.ffi));
                chk("timeout_seen",   64'(o_timeout_seen),   64'(e.to));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(int n);
        repeat (n) begin
            @(posedge clk); #2;
        end
    endtask

    task automatic start_run(input int d[NT], input bit m[NT]);
        begintest = 1'b0;
        tick(1);
        m_prev = model_at(cyc);
        dly = d;
        mis = m;
        begintest = 1'b1;
        m_L0   = cyc + 1;
        m_from = cyc + 1;
        m_mode = 1;
        nstart = 0;
    endtask

    task automatic wait_done();
        int e = m_L0 + run_len();
        while (cyc < e + 1) tick(1);
    endtask

    task automatic final_chk(input string tag, int fails, int ffi, bit to, bit pass, int starts);
        chk({tag, ".endtest"},   64'(o_endtest),        64'(1));
        chk({tag, ".dutpassed"}, 64'(o_dutpassed),      64'(pass));
        chk({tag, ".fail"},      64'(o_fail_count),     64'(fails));
        chk({tag, ".ffi"},       64'(o_first_fail_idx), 64'(ffi));
        chk({tag, ".timeout"},   64'(o_timeout_seen),   64'(to));
        chk({tag, ".starts"},    64'(nstart),           64'(starts));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed scenarios ----------------
    initial begin
        int d5[NT]  = '{5, 5, 5, 5};
        int dto[NT] = '{5, 0, 5, 5};
        int dex[NT] = '{5, TO, 5, 5};
        bit m0[NT]  = '{0, 0, 0, 0};
        bit m23[NT] = '{0, 0, 1, 1};
        int L;

        dly = d5; mis = m0;
        reset = 1'b1; begintest = 1'b0;
        tick(1);
        chk_on = 1'b1;
        tick(1);
        chk("rst.dut_start", 64'(o_dut_start),  64'(0));
        chk("rst.endtest",   64'(o_endtest),    64'(0));
        chk("rst.fail",      64'(o_fail_count), 64'(0));
        reset = 1'b0;
        tick(3);

        // all pass, with done noise during LAUNCH and a mid-run begintest toggle
        noise = 1'b1;
        start_run(d5, m0);
        tick(4);
        begintest = 1'b0; tick(1); begintest = 1'b1;
        wait_done();
        noise = 1'b0;
        final_chk("allpass", 0, 0, 0, 1, 4);
        tick(10);   // begintest held high in DONE: nothing restarts
        chk("hold.starts", 64'(nstart), 64'(4));

        // tests 2 and 3 mismatch
        start_run(d5, m23);
        wait_done();
        final_chk("mismatch", 2, 2, 0, 0, 4);

        // test 1 never answers
        start_run(dto, m0);
        L = m_L0;
        while (cyc < L + 18) tick(1);
        chk("to.start2", 64'(o_dut_start), 64'(1));
        chk("to.idx2",   64'(o_test_idx),  64'(2));
        wait_done();
        final_chk("timeout", 1, 1, 1, 0, 4);

        // done on the expiry cycle counts as a normal compare
        start_run(dex, m0);
        wait_done();
        final_chk("expiry", 0, 0, 0, 1, 4);

        // reset during WAIT of test 2, then restart
        start_run(d5, m0);
        L = m_L0;
        while (cyc < L + 16) tick(1);
        m_prev = model_at(cyc);
        m_from = cyc + 1;
        m_mode = 0;
        reset = 1'b1; begintest = 1'b0;
        tick(1);
        chk("midrst.idx",     64'(o_test_idx),   64'(0));
        chk("midrst.fail",    64'(o_fail_count), 64'(0));
        chk("midrst.endtest", 64'(o_endtest),    64'(0));
        reset = 1'b0;
        tick(5);
        start_run(d5, m0);
        wait_done();
        final_chk("restart", 0, 0, 0, 1, 4);

        // restart from DONE with the mismatch config twice: identical results
        start_run(d5, m23);
        wait_done();
        final_chk("rerun1", 2, 2, 0, 0, 4);
        start_run(d5, m23);
        wait_done();
        final_chk("rerun2", 2, 2, 0, 0, 4);

        tick(2);
        chk_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
